mac: RTL and testbench
======================

// Module: mac
//
// PURPOSE
//  3x3 convolution multiply-accumulate for the image-sharpen pipeline. Takes one
//  3x3 pixel window per cycle from the line-buffer/window stage, convolves it
//  with a signed kernel (default: sharpen), saturates the result to
//  0..2^DATA_WIDTH-1, and emits one output pixel with a valid flag.
//  Fully pipelined: accepts a new window every cycle.
//
// PARAMETERS
//  DATA_WIDTH  8          unsigned pixel width
//  COEF_WIDTH  4          signed two's-complement coefficient width
//  KERNEL      sharpen    9*COEF_WIDTH packed coeffs; coef i = KERNEL[i*COEF_WIDTH +: COEF_WIDTH]
//                         default (raster order, i=0 top-left) {0,-1,0,-1,5,-1,0,-1,0}
//
// PORTS
//  clk            in   1              clock, all logic on rising edge
//  rst            in   1              synchronous, active-low reset (rst==0 resets)
//  inPixel        in   9*DATA_WIDTH   window; pixel i = inPixel[i*DATA_WIDTH +: DATA_WIDTH],
//                                     i = row*3+col, i=0 top-left, i=4 centre, i=8 bottom-right
//  inPixelValid   in   1              qualifies inPixel this cycle
//  outPixel       out  DATA_WIDTH     saturated convolution result
//  outPixelValid  out  1              qualifies outPixel
//
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): all pipeline registers, outPixel, outPixelValid -> 0.
//    In-flight windows are discarded; no valid output for them after reset release.
//  - Stage 1 (edge N, window sampled when inPixelValid==1): prod_i = p_i * coef_i,
//    pixels zero-extended, signed products, registered with a valid bit.
//  - Stage 2 (edge N+1): sum = signed sum of 9 products; accumulator width
//    DATA_WIDTH+COEF_WIDTH+4 (16 bits default) so no overflow for any input/coef.
//    Saturate: sum<0 -> 0; sum>2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1; else sum[DATA_WIDTH-1:0].
//    Register to outPixel; outPixelValid <= stage-1 valid.
//  - Latency: fixed 2 clk; output for window sampled at edge N appears after edge N+1.
//  - Throughput 1 window/cycle, no backpressure; valid bubbles propagate unchanged.
//  - When outPixelValid==0, outPixel holds its last value (data regs load only on valid).
//  - Default kernel range: -1020..1275 before saturation.
//  - inPixel ignored when inPixelValid==0; X on data with valid low must not affect outputs.
//
// STRUCTURE
//  - mac_pkg: DATA_WIDTH/COEF_WIDTH defaults, SHARPEN_KERNEL constant,
//    ACC_WIDTH function/localparam, window index constants (CENTRE=4).
//  - Sub-module mac_sat: combinational signed-ACC_WIDTH -> unsigned DATA_WIDTH clamp.
//  - Top: product generate-loop, stage regs, adder tree, mac_sat, output regs.
//
// TESTING
//  1. All pixels 8'h01, valid 1 cycle -> outPixel=1, outPixelValid high exactly 1 cycle, 2 clk later.
//  2. All pixels 100 -> outPixel=100 (unity-gain on flat region).
//  3. Centre 255, others 0 -> raw 1275, outPixel=255 (upper saturation).
//  4. Centre 0, pixels 1,3,5,7 = 255 -> raw -1020, outPixel=0 (lower saturation).
//  5. Back-to-back windows (cases 1-4 on consecutive cycles, then a 1-cycle bubble)
//     -> outputs 1,100,255,0 on consecutive cycles, valid pattern delayed by 2, bubble preserved.
//  6. Assert rst=0 while windows in flight -> outPixel=0, outPixelValid=0 next edge;
//     no stale valid after release.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants for the 3x3 sharpen multiply-accumulate: default widths,
// the sharpen kernel, window indexing and the accumulator-width rule.
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int COEF_WIDTH_DEF = 4;

  // Window indexing, raster order: i = row*3 + col.
  localparam int TAPS         = 9;
  localparam int TOP_LEFT     = 0;
  localparam int CENTRE       = 4;
  localparam int BOTTOM_RIGHT = 8;

  // Coefficient i sits at bits [i*4 +: 4]; the kernel {0,-1,0,-1,5,-1,0,-1,0}
  // is symmetric, so the packed hex reads the same from either end.
  localparam logic [TAPS*COEF_WIDTH_DEF-1:0] SHARPEN_KERNEL = 36'h0F0F5F0F0;

  // Nine products of a (DATA_WIDTH+1)-bit zero-extended pixel and a signed
  // coefficient never overflow this width.
  function automatic int acc_width(input int data_width, input int coef_width);
    return data_width + coef_width + 4;
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Combinational clamp of a signed accumulator to an unsigned pixel:
// negative -> 0, above the pixel range -> all ones, otherwise pass-through.
module mac_sat
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH_DEF, COEF_WIDTH_DEF)
) (
  input  logic signed [ACC_WIDTH-1:0]  sum_i,
  output logic        [DATA_WIDTH-1:0] pix_o
);

  always_comb begin
    // NOTE: pix_o gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    pix_o = sum_i[DATA_WIDTH-1:0];
    if (sum_i[ACC_WIDTH-1]) begin
      pix_o = '0;
    end else if (|sum_i[ACC_WIDTH-2:DATA_WIDTH]) begin
      pix_o = '1;
    end
  end

endmodule

// File: rtl/mac.sv
// Two-stage 3x3 convolution MAC: stage 1 registers nine signed products,
// stage 2 sums them through an adder tree, saturates and registers the pixel.
module mac
  import mac_pkg::*;
#(
  parameter int                        DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                        COEF_WIDTH = COEF_WIDTH_DEF,
  parameter logic [TAPS*COEF_WIDTH-1:0] KERNEL    = SHARPEN_KERNEL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TAPS*DATA_WIDTH-1:0] inPixel,
  input  logic                       inPixelValid,
  output logic [DATA_WIDTH-1:0]      outPixel,
  output logic                       outPixelValid
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH);

  logic signed [PROD_WIDTH-1:0] prod_d [TAPS];
  logic signed [PROD_WIDTH-1:0] prod_q [TAPS];
  logic                         valid1_q;

  logic signed [ACC_WIDTH-1:0]  prod_ext [TAPS];
  logic signed [ACC_WIDTH-1:0]  sum_l1   [4];
  logic signed [ACC_WIDTH-1:0]  sum_l2   [2];
  logic signed [ACC_WIDTH-1:0]  sum_d;

  logic [DATA_WIDTH-1:0]        sat_d;
  logic [DATA_WIDTH-1:0]        out_q;
  logic                         valid2_q;

  // Per-tap multiplier: the pixel gains a zero sign bit so it multiplies as
  // a non-negative signed value against the two's-complement coefficient.
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    logic signed [DATA_WIDTH:0]   pix_s;
    logic signed [COEF_WIDTH-1:0] coef_s;

    assign pix_s       = $signed({1'b0, inPixel[i*DATA_WIDTH +: DATA_WIDTH]});
    assign coef_s      = $signed(KERNEL[i*COEF_WIDTH +: COEF_WIDTH]);
    assign prod_d[i]   = PROD_WIDTH'(pix_s) * PROD_WIDTH'(coef_s);
    assign prod_ext[i] = ACC_WIDTH'(prod_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the product bank is a small register array, not a RAM, so it
      // is cleared in reset like any other pipeline flop.
      for (int i = 0; i < TAPS; i++) begin
        prod_q[i] <= '0;
      end
      valid1_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, independent of statement order.
      valid1_q <= inPixelValid;
      if (inPixelValid) begin
        for (int i = 0; i < TAPS; i++) begin
          prod_q[i] <= prod_d[i];
        end
      end
    end
  end

  // Balanced tree: four pair sums, two quad sums, then the odd ninth tap.
  for (genvar j = 0; j < 4; j++) begin : g_l1
    assign sum_l1[j] = prod_ext[2*j] + prod_ext[2*j+1];
  end

  assign sum_l2[0] = sum_l1[0] + sum_l1[1];
  assign sum_l2[1] = sum_l1[2] + sum_l1[3];
  assign sum_d     = sum_l2[0] + sum_l2[1] + prod_ext[TAPS-1];

  mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat (
    .sum_i (sum_d),
    .pix_o (sat_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q    <= '0;
      valid2_q <= 1'b0;
    end else begin
      valid2_q <= valid1_q;
      if (valid1_q) begin
        out_q <= sat_d;
      end
    end
  end

  assign outPixel      = out_q;
  assign outPixelValid = valid2_q;

endmodule

// File: tb/tb_mac.sv
// Self-checking bench for mac: directed sharpen cases, back-to-back and
// reset-in-flight sequences, then randomized windows against a cycle-keyed model.
module tb_mac;
  import mac_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;

  typedef logic [TAPS*DW-1:0] win_t;

  logic          clk;
  logic          rst;
  win_t          inPixel;
  logic          inPixelValid;
  logic [DW-1:0] outPixel;
  logic          outPixelValid;

  int n_cmp  = 0;
  int n_fail = 0;

  mac dut (
    .clk           (clk),
    .rst           (rst),
    .inPixel       (inPixel),
    .inPixelValid  (inPixelValid),
    .outPixel      (outPixel),
    .outPixelValid (outPixelValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference convolution straight from the kernel table.
  function automatic int ref_raw(input win_t w);
    int kern [TAPS];
    int s;
    kern = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    s = 0;
    for (int i = 0; i < TAPS; i++) s += int'(w[i*DW +: DW]) * kern[i];
    return s;
  endfunction

  function automatic int ref_pix(input win_t w);
    int s;
    s = ref_raw(w);
    if (s < 0) return 0;
    if (s > (1 << DW) - 1) return (1 << DW) - 1;
    return s;
  endfunction

  function automatic win_t mk_flat(input int v);
    win_t w;
    for (int i = 0; i < TAPS; i++) w[i*DW +: DW] = DW'(v);
    return w;
  endfunction

  function automatic win_t mk_centre(input int c);
    win_t w;
    w = '0;
    w[CENTRE*DW +: DW] = DW'(c);
    return w;
  endfunction

  function automatic win_t mk_cross(input int c, input int e);
    win_t w;
    w = '0;
    w[CENTRE*DW +: DW] = DW'(c);
    for (int i = 1; i < TAPS; i += 2) w[i*DW +: DW] = DW'(e);
    return w;
  endfunction

  // Model: a window accepted at edge N is due at edge N+1; outputs hold otherwise.
  int sched [int];
  int edge_n    = 0;
  int exp_out   = 0;
  int exp_valid = 0;

  always @(posedge clk) begin
    int cur;
    cur = edge_n + 1;
    edge_n <= cur;
    if (!rst) begin
      sched.delete();
      exp_out   <= 0;
      exp_valid <= 0;
    end else begin
      if (inPixelValid) sched[cur + 1] = ref_pix(inPixel);
      if (sched.exists(cur)) begin
        exp_out   <= sched[cur];
        exp_valid <= 1;
        sched.delete(cur);
      end else begin
        exp_valid <= 0;
      end
    end
  end

  // Per-cycle compare plus a log of every valid output for sequence checks.
  int got_q   [$];
  int got_cyc [$];

  always @(negedge clk) begin
    check("cyc_valid", int'(outPixelValid), exp_valid);
    check("cyc_pixel", int'(outPixel), exp_out);
    if (outPixelValid) begin
      got_q.push_back(int'(outPixel));
      got_cyc.push_back(edge_n);
    end
  end

  task automatic drive(input win_t w, input logic v);
    inPixelValid = v;
    inPixel      = v ? w : 'x;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0);
  endtask

  task automatic run_single(input string name, input win_t w, input int expv);
    int sent;
    got_q.delete();
    got_cyc.delete();
    sent = edge_n;
    drive(w, 1'b1);
    idle(4);
    check({name, "_count"}, got_q.size(), 1);
    if (got_q.size() == 1) begin
      check({name, "_pixel"}, got_q[0], expv);
      check({name, "_latency"}, got_cyc[0] - sent, 2);
    end
  endtask

  initial begin
    win_t w;
    int   expv [5];
    int   gaps [4];

    rst          = 1'b0;
    inPixelValid = 1'b0;
    inPixel      = '0;
    repeat (3) @(negedge clk);

    check("reset_pixel", int'(outPixel), 0);
    check("reset_valid", int'(outPixelValid), 0);

    // Pin the model against hand-computed values.
    check("model_flat1", ref_pix(mk_flat(1)), 1);
    check("model_flat100", ref_pix(mk_flat(100)), 100);
    check("model_raw_hi", ref_raw(mk_centre(255)), 1275);
    check("model_raw_lo", ref_raw(mk_cross(0, 255)), -1020);

    rst = 1'b1;
    idle(2);

    run_single("flat1", mk_flat(1), 1);
    run_single("flat100", mk_flat(100), 100);
    run_single("sat_hi", mk_centre(255), 255);
    run_single("sat_lo", mk_cross(0, 255), 0);

    // Back-to-back windows with a single bubble before the fifth.
    got_q.delete();
    got_cyc.delete();
    drive(mk_flat(1), 1'b1);
    drive(mk_flat(100), 1'b1);
    drive(mk_centre(255), 1'b1);
    drive(mk_cross(0, 255), 1'b1);
    drive('0, 1'b0);
    drive(mk_flat(1), 1'b1);
    idle(4);
    expv = '{1, 100, 255, 0, 1};
    gaps = '{1, 1, 1, 2};
    check("b2b_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("b2b_pixel%0d", i), got_q[i], expv[i]);
      for (int i = 0; i < 4; i++)
        check($sformatf("b2b_gap%0d", i), got_cyc[i+1] - got_cyc[i], gaps[i]);
    end

    // Reset while windows are in flight.
    drive(mk_flat(100), 1'b1);
    drive(mk_flat(100), 1'b1);
    drive(mk_flat(100), 1'b1);
    rst          = 1'b0;
    inPixelValid = 1'b0;
    inPixel      = 'x;
    @(negedge clk);
    check("inflight_rst_pixel", int'(outPixel), 0);
    check("inflight_rst_valid", int'(outPixelValid), 0);
    got_q.delete();
    got_cyc.delete();
    rst = 1'b1;
    idle(5);
    check("no_stale_valid", got_q.size(), 0);

    // Randomized traffic with biased extremes and rare reset pulses.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < TAPS; i++) begin
        case ($urandom_range(0, 3))
          0:       w[i*DW +: DW] = '0;
          1:       w[i*DW +: DW] = '1;
          default: w[i*DW +: DW] = DW'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      drive(w, ($urandom_range(0, 9) < 7));
    end
    rst = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
